hack_boot_loader: RTL and testbench

Parametrised program-load controller for the HACK CPU's instruction memory. It accepts a word stream over a valid/ready handshake and writes it into instruction memory at auto-incrementing addresses from a programmable base. An optional checksum read-back verify pass follows the load. The CPU is held in reset until the image is loaded and verified. The block sits between an external loader (UART/host) and the instruction RAM, and replaces the single-cycle external address/data/load strobing of the first-generation top level.

---
 rtl/hack_boot_loader.sv | 173 +++++++++++++++++
 tb/tb_hack_boot_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_boot_loader.sv
// hack_boot_loader
//
// Program-load controller for the HACK CPU instruction memory. A word stream
// arriving over a valid/ready handshake is written to instruction memory at
// auto-incrementing addresses starting from a programmable base. When VERIFY
// is nonzero, a read-back pass follows the load and compares the sum of the
// words read back with the sum of the words written. The CPU is held in reset
// until the image has been loaded (and verified, if enabled).
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        asynchronous active-low reset
//   start      begin a load; honoured in IDLE, RUN and ERROR
//   abort      cancel a load or verify and return to IDLE
//   base       first memory address, captured on an accepted start
//   len        word count, captured on an accepted start; saturates at 2^ADDR_W
//   in_data    stream word
//   in_valid   stream word valid
//   in_ready   loader accepts a word this cycle
//   mem_addr   instruction-memory address
//   mem_wdata  write data (mirrors in_data)
//   mem_we     write strobe
//   mem_rdata  asynchronous read data for mem_addr
//   cpu_rst    active-high CPU reset (registered)
//   busy       high during LOAD or VERIFY
//   done       one-cycle pulse on entry to RUN
//   error      high while in ERROR
//   checksum   sum of the words written in the last load
module hack_boot_loader #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16,
    parameter int VERIFY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {
        st_idle,
        st_load,
        st_verify,
        st_run,
        st_error
    } state_t;

    localparam logic [ADDR_W:0] len_max = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] cnt_one = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     count_q;
    logic [DATA_W-1:0]   checksum_q;
    logic [DATA_W-1:0]   vsum_q;
    logic                cpu_rst_q;
    logic                done_q;

    logic [ADDR_W:0]     len_sat;
    logic [ADDR_W:0]     count_inc;
    logic [DATA_W-1:0]   vsum_next;
    logic                start_go;
    logic                accept;
    logic                last;
    logic                enter_run;

    // Next-state and handshake decode
    always_comb begin
        len_sat   = (len > len_max) ? len_max : len;
        count_inc = count_q + cnt_one;
        vsum_next = vsum_q + mem_rdata;
        last      = (count_inc == len_q);
        // abort beats start whenever both are high
        start_go  = start && !abort &&
                    (state_q inside {st_idle, st_run, st_error});
        accept    = (state_q == st_load) && in_valid && !abort;
        state_d   = state_q;

        case (state_q)
            st_idle, st_run, st_error: begin
                if (start_go) begin
                    state_d = (len_sat == '0) ? st_run : st_load;
                end
            end
            st_load: begin
                if (abort) begin
                    state_d = st_idle;
                end else if (accept && last) begin
                    state_d = (VERIFY != 0) ? st_verify : st_run;
                end
            end
            st_verify: begin
                if (abort) begin
                    state_d = st_idle;
                end else if (last) begin
                    // The final read is folded in combinationally so the
                    // decision lands on the same edge as that read.
                    state_d = (vsum_next == checksum_q) ? st_run : st_error;
                end
            end
            default: state_d = st_idle;
        endcase

        // A zero-length start issued from RUN re-enters RUN and pulses done.
        enter_run = (state_d == st_run) && ((state_q != st_run) || start_go);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q     <= '0;
            len_q      <= '0;
            count_q    <= '0;
            checksum_q <= '0;
            vsum_q     <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            if (start_go) begin
                base_q     <= base;
                len_q      <= len_sat;
                count_q    <= '0;
                checksum_q <= '0;
                vsum_q     <= '0;
            end else if (accept) begin
                checksum_q <= checksum_q + in_data;
                // Counter restarts at zero so the verify pass walks the
                // same address range from base.
                count_q    <= last ? '0 : count_inc;
            end else if (state_q == st_verify) begin
                vsum_q     <= vsum_next;
                count_q    <= count_inc;
            end
            cpu_rst_q <= (state_d != st_run);
            done_q    <= enter_run;
        end
    end

    always_comb begin
        busy      = (state_q == st_load) || (state_q == st_verify);
        in_ready  = (state_q == st_load);
        mem_we    = (state_q == st_load) && in_valid;
        mem_addr  = busy ? (base_q + count_q[ADDR_W-1:0]) : '0;
        mem_wdata = in_data;
        error     = (state_q == st_error);
        cpu_rst   = cpu_rst_q;
        done      = done_q;
        checksum  = checksum_q;
    end

endmodule

// File: tb/tb_hack_boot_loader.sv
// tb_hack_boot_loader
//
// Directed bench for hack_boot_loader with default parameters (ADDR_W=15,
// DATA_W=16, VERIFY=1). A behavioural async-read RAM sits on the memory port
// and records every write so addresses and data can be compared with
// hand-computed expectations.
module tb_hack_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [14:0] base;
    logic [15:0] len;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] checksum;

    always #5 clk = ~clk;

    hack_boot_loader #(
        .ADDR_W (15),
        .DATA_W (16),
        .VERIFY (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .base      (base),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum)
    );

    // Behavioural RAM; 'corrupt' makes address 2 read back as 0x0013.
    logic [15:0] mem [0:32767];
    logic        corrupt;
    logic [14:0] wr_addr [$];
    logic [15:0] wr_data [$];

    assign mem_rdata = (corrupt && mem_addr == 15'd2) ? 16'h0013 : mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int t0       = 0;
    int lat;
    logic se;

    logic [15:0] w1 [0:3] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    logic [15:0] w2 [0:3] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [14:0] a2 [0:3] = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    logic        v4 [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] d4 [0:4] = '{16'h0010, 16'hDEAD, 16'h0020, 16'hBEEF, 16'h0030};
    logic [15:0] e4 [0:2] = '{16'h0010, 16'h0020, 16'h0030};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_start(input logic [14:0] b, input logic [15:0] l);
        base  = b;
        len   = l;
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic v, input logic [15:0] d);
        in_valid = v;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for done or error; latency is counted from the start cycle.
    task automatic wait_end(output int l, output logic e);
        l = -1;
        e = 1'b0;
        for (int k = 0; k < 40 && l < 0; k++) begin
            if (done || error) begin
                l = cyc - t0;
                e = error;
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; base = '0; len = '0;
        in_data = '0; in_valid = 1'b0; corrupt = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_cpu_rst",  32'(cpu_rst),  1);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mem_we",   32'(mem_we),   0);
        check("rst_busy",     32'(busy),     0);
        check("rst_done",     32'(done),     0);
        check("rst_error",    32'(error),    0);
        check("rst_checksum", 32'(checksum), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        rst = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 0);

        // Basic load + verify, base 0, four words
        wr_addr.delete(); wr_data.delete();
        do_start(15'h0000, 16'd4);
        check("t1_in_ready", 32'(in_ready), 1);
        check("t1_busy",     32'(busy),     1);
        check("t1_addr0",    32'(mem_addr), 0);
        for (int i = 0; i < 4; i++) feed(1'b1, w1[i]);
        check("t1_verify_in_ready", 32'(in_ready), 0);
        check("t1_verify_cpu_rst",  32'(cpu_rst),  1);
        wait_end(lat, se);
        check("t1_latency", 32'(lat), 9);
        check("t1_err",     32'(se),  0);
        check("t1_cpu_rst_at_done", 32'(cpu_rst), 0);
        check("t1_checksum", 32'(checksum), 'h000A);
        check("t1_wr_count", 32'(wr_addr.size()), 4);
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            check("t1_wr_addr", 32'(wr_addr[i]), 32'(i));
            check("t1_wr_data", 32'(wr_data[i]), 32'(w1[i]));
        end
        tick();
        check("t1_done_pulse_end", 32'(done),    0);
        check("t1_run_cpu_rst",    32'(cpu_rst), 0);

        // Address wrap from 0x7FFE, restarted from RUN
        wr_addr.delete(); wr_data.delete();
        do_start(15'h7FFE, 16'd4);
        check("t2_cpu_rst_reload", 32'(cpu_rst), 1);
        for (int i = 0; i < 4; i++) feed(1'b1, w2[i]);
        wait_end(lat, se);
        check("t2_latency",  32'(lat), 9);
        check("t2_err",      32'(se),  0);
        check("t2_checksum", 32'(checksum), 'hAAAA);
        check("t2_wr_count", 32'(wr_addr.size()), 4);
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            check("t2_wr_addr", 32'(wr_addr[i]), 32'(a2[i]));
            check("t2_wr_data", 32'(wr_data[i]), 32'(w2[i]));
        end

        // Corrupted read-back -> ERROR, then clean reload from ERROR
        do_start(15'h0000, 16'd4);
        for (int i = 0; i < 4; i++) feed(1'b1, w1[i]);
        corrupt = 1'b1;
        wait_end(lat, se);
        check("t3_err_latency", 32'(lat),     9);
        check("t3_err_seen",    32'(se),      1);
        check("t3_done",        32'(done),    0);
        check("t3_cpu_rst",     32'(cpu_rst), 1);
        tick();
        check("t3_error_held",  32'(error),   1);
        check("t3_cpu_rst_held", 32'(cpu_rst), 1);
        corrupt = 1'b0;
        do_start(15'h0000, 16'd4);
        check("t3_error_clear", 32'(error), 0);
        for (int i = 0; i < 4; i++) feed(1'b1, w1[i]);
        wait_end(lat, se);
        check("t3_reload_latency", 32'(lat), 9);
        check("t3_reload_err",     32'(se),  0);
        check("t3_reload_cpu_rst", 32'(cpu_rst), 0);

        // in_valid gaps during LOAD
        wr_addr.delete(); wr_data.delete();
        do_start(15'h0100, 16'd3);
        for (int i = 0; i < 5; i++) feed(v4[i], d4[i]);
        wait_end(lat, se);
        check("t4_latency",  32'(lat), 9);
        check("t4_err",      32'(se),  0);
        check("t4_checksum", 32'(checksum), 'h0060);
        check("t4_wr_count", 32'(wr_addr.size()), 3);
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            check("t4_wr_addr", 32'(wr_addr[i]), 32'h100 + 32'(i));
            check("t4_wr_data", 32'(wr_data[i]), 32'(e4[i]));
        end

        // abort together with start mid-load, then zero-length start
        do_start(15'h0200, 16'd5);
        feed(1'b1, 16'h0005);
        feed(1'b1, 16'h0006);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("t5_abort_busy",     32'(busy),     0);
        check("t5_abort_cpu_rst",  32'(cpu_rst),  1);
        check("t5_abort_in_ready", 32'(in_ready), 0);
        check("t5_abort_done",     32'(done),     0);
        wr_addr.delete(); wr_data.delete();
        in_valid = 1'b1; in_data = 16'h0077;
        repeat (3) tick();
        in_valid = 1'b0;
        check("t5_no_writes", 32'(wr_addr.size()), 0);
        do_start(15'h0000, 16'd0);
        check("t5_len0_done",     32'(done),     1);
        check("t5_len0_cpu_rst",  32'(cpu_rst),  0);
        check("t5_len0_checksum", 32'(checksum), 0);
        check("t5_len0_busy",     32'(busy),     0);
        tick();
        check("t5_len0_done_end", 32'(done), 0);

        // Asynchronous reset between edges during LOAD
        do_start(15'h0000, 16'd4);
        feed(1'b1, 16'h0009);
        in_valid = 1'b1; in_data = 16'h000A;
        check("t6_we_before", 32'(mem_we), 1);
        #2 rst = 1'b0;
        #1;
        check("t6_cpu_rst",  32'(cpu_rst),  1);
        check("t6_mem_we",   32'(mem_we),   0);
        check("t6_in_ready", 32'(in_ready), 0);
        check("t6_busy",     32'(busy),     0);
        check("t6_checksum", 32'(checksum), 0);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        tick();
        check("t6_post_busy",    32'(busy),    0);
        check("t6_post_cpu_rst", 32'(cpu_rst), 1);
        check("t6_post_mem_we",  32'(mem_we),  0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
